vexriscv_bus_arbiter: RTL and testbench
=======================================

VEXRISCV_BUS_ARBITER -- requirements
Module: vexriscv_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive dBus grants tolerated while iBus waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: max cycles waiting for a read response.
REQ-003 SHALL have port clk_cpu  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port clk_cpu_reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have iBus_cmd_valid in 1, iBus_cmd_ready out 1, iBus_cmd_payload_pc in 32: fetch request.
REQ-006 SHALL have iBus_rsp_valid out 1, iBus_rsp_payload_error out 1, iBus_rsp_payload_inst out 32: fetch response.
REQ-007 SHALL have dBus_cmd_valid in 1, dBus_cmd_ready out 1, dBus_cmd_payload_wr in 1, dBus_cmd_payload_address in 32, dBus_cmd_payload_data in 32, dBus_cmd_payload_size in 2: data request.
REQ-008 SHALL have dBus_rsp_ready out 1, dBus_rsp_error out 1, dBus_rsp_data out 32: data read response.
REQ-009 SHALL have mem_cmd_valid out 1, mem_cmd_ready in 1, mem_cmd_wr out 1, mem_cmd_addr out 32, mem_cmd_wdata out 32, mem_cmd_size out 2: shared memory command.
REQ-010 SHALL have mem_rsp_valid in 1, mem_rsp_data in 32, mem_rsp_error in 1: shared memory read response.
REQ-011 SHALL have protocol_error out 1: sticky flag, unexpected or late response seen.

Function
REQ-012 SHALL implement FSM states IDLE, I_PEND, D_PEND; one outstanding read max.
REQ-013 In IDLE, grant SHALL go to dBus when dBus_cmd_valid, unless starve_cnt == STARVE_LIMIT and iBus_cmd_valid, then iBus.
REQ-014 In IDLE with only one requester valid, that requester SHALL be granted.
REQ-015 mem_cmd_* SHALL combinationally mirror the granted requester in IDLE; iBus grant drives mem_cmd_wr=0, mem_cmd_size=2'b10, mem_cmd_wdata=0.
REQ-016 Granted requester's cmd_ready SHALL equal mem_cmd_ready; non-granted cmd_ready SHALL be 0; in I_PEND/D_PEND mem_cmd_valid and both cmd_ready SHALL be 0.
REQ-017 Accepted dBus write SHALL stay in IDLE (no response); next command may issue next cycle.
REQ-018 Accepted iBus read SHALL go to I_PEND; accepted dBus read SHALL go to D_PEND.
REQ-019 starve_cnt (saturating at STARVE_LIMIT) SHALL increment on each accepted dBus command while iBus_cmd_valid=1, and clear on accepted iBus command.
REQ-020 In I_PEND, mem_rsp_valid SHALL pass same cycle to iBus_rsp_valid/inst/error; in D_PEND to dBus_rsp_ready/data/error; FSM returns to IDLE next cycle.
REQ-021 Response outputs SHALL be 0 when not forwarding; other requester's response outputs SHALL stay 0.
REQ-022 timeout counter SHALL clear on entering a PEND state, increment each PEND cycle; at TIMEOUT with no mem_rsp_valid, SHALL emit one-cycle response to pending requester with error=1, data=0, then go IDLE.
REQ-023 mem_rsp_valid in IDLE (incl. late response after timeout) SHALL be dropped and set protocol_error until reset.
REQ-024 Response and timeout in same cycle: response SHALL win, error=mem_rsp_error.

Reset
REQ-025 Asserting clk_cpu_reset SHALL immediately force IDLE, starve_cnt=0, timeout=0, protocol_error=0, all valid/ready outputs 0.
REQ-026 Reset mid-transaction SHALL abandon pending read; no response emitted; later stray response sets protocol_error.

Verification
REQ-027 Both valid, mem_cmd_ready=1, dBus reads answered 1 cycle later -> dBus granted 3 times, 4th grant iBus, starve_cnt back to 0.
REQ-028 dBus write addr 0x100 data 0xDEADBEEF size 2 -> mem_cmd_wr=1 mirrored, dBus_cmd_ready=1, no rsp, iBus fetch accepted next cycle.
REQ-029 iBus pc 0x80 accepted, mem_rsp_valid with 0x00000013 3 cycles later -> iBus_rsp_valid=1, inst=0x00000013, error=0, dBus_rsp_ready=0.
REQ-030 dBus read with no response -> after 255 PEND cycles dBus_rsp_ready=1, error=1, data=0; response at cycle 260 -> protocol_error=1.
REQ-031 Reset asserted during D_PEND -> outputs 0 same cycle, IDLE after release, new iBus fetch accepted normally.

Source files
------------

// File: rtl/vexriscv_bus_arbiter_if.sv
// Bus bundle between the VexRiscv iBus/dBus, the arbiter and the shared memory port.
// master = arbiter view, slave = CPU + memory environment view.
interface vexriscv_bus_arbiter_if;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_valid;
    logic        iBus_rsp_payload_error;
    logic [31:0] iBus_rsp_payload_inst;

    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_address;
    logic [31:0] dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready;
    logic        dBus_rsp_error;
    logic [31:0] dBus_rsp_data;

    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_wr;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic [1:0]  mem_cmd_size;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_error;

    modport master (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
               dBus_cmd_payload_data, dBus_cmd_payload_size,
        output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_size,
        input  mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error
    );

    modport slave (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
               dBus_cmd_payload_data, dBus_cmd_payload_size,
        input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_size,
        output mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error
    );
endinterface

// File: rtl/vexriscv_bus_arbiter.sv
// Arbitrates VexRiscv iBus/dBus onto one memory port: dBus priority with iBus
// anti-starvation, single outstanding read, read timeout and stray-response flag.
module vexriscv_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                         clk_cpu,
    input  logic                         clk_cpu_reset,
    vexriscv_bus_arbiter_if.master       bus,
    output logic                         protocol_error
);
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, I_PEND, D_PEND} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          perr_q, perr_d;
    logic          gnt_d_bus;

    always_ff @(posedge clk_cpu or posedge clk_cpu_reset) begin
        if (clk_cpu_reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            perr_q   <= perr_d;
        end
    end

    assign protocol_error = perr_q;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        perr_d    = perr_q;
        gnt_d_bus = 1'b0;

        bus.iBus_cmd_ready         = 1'b0;
        bus.iBus_rsp_valid         = 1'b0;
        bus.iBus_rsp_payload_error = 1'b0;
        bus.iBus_rsp_payload_inst  = '0;
        bus.dBus_cmd_ready         = 1'b0;
        bus.dBus_rsp_ready         = 1'b0;
        bus.dBus_rsp_error         = 1'b0;
        bus.dBus_rsp_data          = '0;
        bus.mem_cmd_valid          = 1'b0;
        bus.mem_cmd_wr             = 1'b0;
        bus.mem_cmd_addr           = '0;
        bus.mem_cmd_wdata          = '0;
        bus.mem_cmd_size           = '0;

        unique case (state_q)
            IDLE: begin
                // Any response here has no owner: drop it, remember the violation.
                if (bus.mem_rsp_valid) perr_d = 1'b1;
                gnt_d_bus = bus.dBus_cmd_valid &&
                            !(bus.iBus_cmd_valid && starve_q == SLIM);
                if (gnt_d_bus) begin
                    bus.mem_cmd_valid  = 1'b1;
                    bus.mem_cmd_wr     = bus.dBus_cmd_payload_wr;
                    bus.mem_cmd_addr   = bus.dBus_cmd_payload_address;
                    bus.mem_cmd_wdata  = bus.dBus_cmd_payload_data;
                    bus.mem_cmd_size   = bus.dBus_cmd_payload_size;
                    bus.dBus_cmd_ready = bus.mem_cmd_ready;
                    if (bus.mem_cmd_ready) begin
                        if (bus.iBus_cmd_valid && starve_q != SLIM) starve_d = starve_q + 1'b1;
                        if (!bus.dBus_cmd_payload_wr) begin
                            state_d = D_PEND;
                            tmo_d   = '0;
                        end
                    end
                end else if (bus.iBus_cmd_valid) begin
                    bus.mem_cmd_valid  = 1'b1;
                    bus.mem_cmd_addr   = bus.iBus_cmd_payload_pc;
                    bus.mem_cmd_size   = 2'b10;
                    bus.iBus_cmd_ready = bus.mem_cmd_ready;
                    if (bus.mem_cmd_ready) begin
                        starve_d = '0;
                        state_d  = I_PEND;
                        tmo_d    = '0;
                    end
                end
            end
            I_PEND: begin
                if (bus.mem_rsp_valid) begin
                    bus.iBus_rsp_valid         = 1'b1;
                    bus.iBus_rsp_payload_inst  = bus.mem_rsp_data;
                    bus.iBus_rsp_payload_error = bus.mem_rsp_error;
                    state_d                    = IDLE;
                end else if (tmo_q == TLIM) begin
                    bus.iBus_rsp_valid         = 1'b1;
                    bus.iBus_rsp_payload_error = 1'b1;
                    state_d                    = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            D_PEND: begin
                if (bus.mem_rsp_valid) begin
                    bus.dBus_rsp_ready = 1'b1;
                    bus.dBus_rsp_data  = bus.mem_rsp_data;
                    bus.dBus_rsp_error = bus.mem_rsp_error;
                    state_d            = IDLE;
                end else if (tmo_q == TLIM) begin
                    bus.dBus_rsp_ready = 1'b1;
                    bus.dBus_rsp_error = 1'b1;
                    state_d            = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs must drop the moment reset asserts, not at the next edge.
        if (clk_cpu_reset) begin
            bus.iBus_cmd_ready         = 1'b0;
            bus.iBus_rsp_valid         = 1'b0;
            bus.iBus_rsp_payload_error = 1'b0;
            bus.iBus_rsp_payload_inst  = '0;
            bus.dBus_cmd_ready         = 1'b0;
            bus.dBus_rsp_ready         = 1'b0;
            bus.dBus_rsp_error         = 1'b0;
            bus.dBus_rsp_data          = '0;
            bus.mem_cmd_valid          = 1'b0;
        end
    end
endmodule

// File: tb/tb_vexriscv_bus_arbiter.sv
// Directed bench for vexriscv_bus_arbiter: write mirroring, fetch, starvation,
// timeout, late response and reset abandonment.
module tb_vexriscv_bus_arbiter;
    logic clk_cpu = 1'b0;
    logic clk_cpu_reset;
    logic protocol_error;
    int   n_cmp = 0;
    int   n_err = 0;
    int   early;

    vexriscv_bus_arbiter_if bus();

    vexriscv_bus_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(255)) dut (
        .clk_cpu        (clk_cpu),
        .clk_cpu_reset  (clk_cpu_reset),
        .bus            (bus),
        .protocol_error (protocol_error)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clk_cpu_reset                = 1'b1;
        bus.iBus_cmd_valid           = 1'b1;
        bus.iBus_cmd_payload_pc      = 32'h0;
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = 32'h0;
        bus.dBus_cmd_payload_data    = 32'h0;
        bus.dBus_cmd_payload_size    = 2'b10;
        bus.mem_cmd_ready            = 1'b1;
        bus.mem_rsp_valid            = 1'b0;
        bus.mem_rsp_data             = 32'h0;
        bus.mem_rsp_error            = 1'b0;
        #3;
        chk("rst_mem_cmd_valid", bus.mem_cmd_valid, 0);
        chk("rst_iBus_cmd_ready", bus.iBus_cmd_ready, 0);
        chk("rst_dBus_cmd_ready", bus.dBus_cmd_ready, 0);
        chk("rst_protocol_error", protocol_error, 0);
        tick(); tick();
        bus.iBus_cmd_valid = 1'b0;
        bus.dBus_cmd_valid = 1'b0;
        clk_cpu_reset      = 1'b0;

        // dBus write: mirrored, accepted, no response, iBus fetch next cycle
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_wr      = 1'b1;
        bus.dBus_cmd_payload_address = 32'h100;
        bus.dBus_cmd_payload_data    = 32'hDEADBEEF;
        bus.dBus_cmd_payload_size    = 2'b10;
        #1;
        chk("wr_mem_cmd_valid", bus.mem_cmd_valid, 1);
        chk("wr_mem_cmd_wr", bus.mem_cmd_wr, 1);
        chk("wr_mem_cmd_addr", bus.mem_cmd_addr, 32'h100);
        chk("wr_mem_cmd_wdata", bus.mem_cmd_wdata, 32'hDEADBEEF);
        chk("wr_mem_cmd_size", bus.mem_cmd_size, 2);
        chk("wr_dBus_cmd_ready", bus.dBus_cmd_ready, 1);
        chk("wr_iBus_cmd_ready", bus.iBus_cmd_ready, 0);
        tick();
        bus.dBus_cmd_valid      = 1'b0;
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h80;
        #1;
        chk("wr_no_drsp", bus.dBus_rsp_ready, 0);
        chk("f_iBus_cmd_ready", bus.iBus_cmd_ready, 1);
        chk("f_mem_cmd_addr", bus.mem_cmd_addr, 32'h80);
        chk("f_mem_cmd_wr", bus.mem_cmd_wr, 0);
        chk("f_mem_cmd_size", bus.mem_cmd_size, 2);
        chk("f_mem_cmd_wdata", bus.mem_cmd_wdata, 0);
        tick();

        // I_PEND: commands blocked, response 3 cycles after acceptance
        bus.dBus_cmd_valid      = 1'b1;
        bus.dBus_cmd_payload_wr = 1'b0;
        #1;
        chk("ip_mem_cmd_valid", bus.mem_cmd_valid, 0);
        chk("ip_dBus_cmd_ready", bus.dBus_cmd_ready, 0);
        chk("ip_iBus_cmd_ready", bus.iBus_cmd_ready, 0);
        chk("ip_no_irsp", bus.iBus_rsp_valid, 0);
        tick(); tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h00000013;
        #1;
        chk("f_iBus_rsp_valid", bus.iBus_rsp_valid, 1);
        chk("f_iBus_rsp_inst", bus.iBus_rsp_payload_inst, 32'h13);
        chk("f_iBus_rsp_error", bus.iBus_rsp_payload_error, 0);
        chk("f_dBus_rsp_ready", bus.dBus_rsp_ready, 0);
        chk("f_dBus_rsp_data", bus.dBus_rsp_data, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;

        // Starvation: three dBus reads, then iBus, then dBus again
        bus.iBus_cmd_valid           = 1'b1;
        bus.iBus_cmd_payload_pc      = 32'h300;
        bus.dBus_cmd_payload_address = 32'h200;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sv_dBus_cmd_ready", bus.dBus_cmd_ready, 1);
            chk("sv_iBus_cmd_ready", bus.iBus_cmd_ready, 0);
            chk("sv_mem_cmd_addr", bus.mem_cmd_addr, 32'h200);
            tick();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'h1000 + k;
            #1;
            chk("sv_dBus_rsp_ready", bus.dBus_rsp_ready, 1);
            chk("sv_dBus_rsp_data", bus.dBus_rsp_data, 32'h1000 + k);
            chk("sv_iBus_rsp_valid", bus.iBus_rsp_valid, 0);
            tick();
            bus.mem_rsp_valid = 1'b0;
        end
        #1;
        chk("sv4_iBus_cmd_ready", bus.iBus_cmd_ready, 1);
        chk("sv4_dBus_cmd_ready", bus.dBus_cmd_ready, 0);
        chk("sv4_mem_cmd_addr", bus.mem_cmd_addr, 32'h300);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h13;
        #1;
        chk("sv4_iBus_rsp_valid", bus.iBus_rsp_valid, 1);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("sv5_dBus_cmd_ready", bus.dBus_cmd_ready, 1);
        chk("sv5_iBus_cmd_ready", bus.iBus_cmd_ready, 0);
        bus.iBus_cmd_valid = 1'b0;
        tick();

        // Timeout: silent read, error response in PEND cycle 256, late rsp at 260
        bus.dBus_cmd_valid = 1'b0;
        early = 0;
        for (int n = 1; n <= 255; n++) begin
            if (bus.dBus_rsp_ready) early++;
            tick();
        end
        chk("to_no_early_rsp", early, 0);
        chk("to_dBus_rsp_ready", bus.dBus_rsp_ready, 1);
        chk("to_dBus_rsp_error", bus.dBus_rsp_error, 1);
        chk("to_dBus_rsp_data", bus.dBus_rsp_data, 0);
        chk("to_iBus_rsp_valid", bus.iBus_rsp_valid, 0);
        tick(); tick(); tick(); tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hABCD;
        #1;
        chk("late_dropped", bus.dBus_rsp_ready, 0);
        chk("late_perr_before", protocol_error, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("late_perr_set", protocol_error, 1);

        // Reset during D_PEND abandons the read
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_address = 32'h400;
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h55;
        #1;
        chk("rp_fwd_before_rst", bus.dBus_rsp_ready, 1);
        clk_cpu_reset = 1'b1;
        #1;
        chk("rp_dBus_rsp_ready", bus.dBus_rsp_ready, 0);
        chk("rp_dBus_rsp_data", bus.dBus_rsp_data, 0);
        chk("rp_mem_cmd_valid", bus.mem_cmd_valid, 0);
        chk("rp_dBus_cmd_ready", bus.dBus_cmd_ready, 0);
        chk("rp_protocol_error", protocol_error, 0);
        tick();
        bus.mem_rsp_valid  = 1'b0;
        bus.dBus_cmd_valid = 1'b0;
        clk_cpu_reset      = 1'b0;
        #1;
        chk("rp_perr_after_rel", protocol_error, 0);
        bus.mem_rsp_valid = 1'b1;
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("rp_stray_perr", protocol_error, 1);
        bus.iBus_cmd_valid      = 1'b1;
        bus.iBus_cmd_payload_pc = 32'h84;
        #1;
        chk("rp_iBus_cmd_ready", bus.iBus_cmd_ready, 1);
        chk("rp_mem_cmd_addr", bus.mem_cmd_addr, 32'h84);
        tick();
        bus.iBus_cmd_valid = 1'b0;
        bus.mem_rsp_valid  = 1'b1;
        bus.mem_rsp_data   = 32'h00100093;
        #1;
        chk("rp_iBus_rsp_valid", bus.iBus_rsp_valid, 1);
        chk("rp_iBus_rsp_inst", bus.iBus_rsp_payload_inst, 32'h00100093);
        tick();
        bus.mem_rsp_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
